cart_command: RTL
=================

# cart_command

Command decoder and cartridge bus master sitting directly downstream of the 16-bit SPI slave. It consumes each received word (RX qualified by the one-cycle RDY pulse) as a command or command argument. It runs timed GBA cartridge ROM read/write cycles on the multiplexed AD bus, and presents results or status on TX for the SPI slave to shift out.

## Interface
Parameters:
- SETUP_CYCLES, 2, CLK cycles address is driven before CS_N falls (1..15)
- STROBE_CYCLES, 4, CLK cycles RD_N/WR_N held low (1..15)
- HOLD_CYCLES, 1, CLK cycles CS_N stays low after strobe release (1..15)

Ports:
- CLK  in  1  internal clock; the only clock
- RST  in  1  synchronous, active-high reset
- RX  in  16  word received from SPI slave
- RDY  in  1  one-cycle pulse: RX holds a new word
- TX  out  16  response word, registered, sampled by SPI slave at RDY
- BUSY  out  1  bus cycle in progress
- CART_A  out  8  cartridge A[23:16]
- CART_AD_OUT  out  16  value driven onto AD[15:0]
- CART_AD_OE  out  1  AD output enable (tristate at top level)
- CART_AD_IN  in  16  AD[15:0] input (already synchronised at top level)
- CART_CS_N, CART_RD_N, CART_WR_N  out  1 each  active-low strobes

## Operation
- 24-bit word-address register ADDR; reset 0.
- Command word: RX[15:12] opcode, RX[11:0] operand.
  - 0x0 NOP: no action.
  - 0x1 SET_HI: ADDR[23:16] <= RX[7:0].
  - 0x2 SET_LO: next word is taken whole as ADDR[15:0] (state ARG_ADDR).
  - 0x3 READ: one bus read at ADDR; TX <= data read; ADDR <= ADDR+1.
  - 0x4 WRITE: next word is data (state ARG_DATA), then one bus write at ADDR; ADDR <= ADDR+1.
  - Other opcodes: ignored; set ERR.
- Decoder states: IDLE, ARG_ADDR, ARG_DATA.
- Bus states: B_IDLE, SETUP, LATCH, STROBE, HOLD.
- ADDR increment wraps from 0xFFFFFF to 0x000000.
- Status word is {4'hA, last opcode, 7'b0, ERR}.
  - TX <= status on every accepted word except READ, which loads data when its cycle ends.
  - ERR clears after being reported once.
- Overrun: an RDY arriving while BUSY=1 drops the word and sets ERR.
  - The in-flight cycle completes normally.
  - The decoder state is unchanged.
- Response pipeline: the response to word N appears in TX before the end of word N+1, so it is shifted out during word N+2. The host therefore sends one NOP after each READ.

## Timing
- Reset values: TX=0x0000, BUSY=0, CART_A=0x00, CART_AD_OUT=0x0000, CART_AD_OE=0, CS_N=RD_N=WR_N=1, decoder IDLE, ADDR=0, ERR=0.
- RST is checked at each CLK edge and overrides everything.
  - Reset mid-cycle releases all strobes and OE on the same edge.
  - No completion is reported.
- Non-bus commands: TX updated on the edge after RDY (1-cycle latency).
- A bus cycle starts on the edge after RDY (READ command, or the ARG_DATA word for WRITE); BUSY=1 from that edge.
- SETUP (SETUP_CYCLES): CART_A=ADDR[23:16], AD_OUT=ADDR[15:0], OE=1, CS_N=1.
- LATCH (1 cycle): CS_N=0, address still driven.
- STROBE (STROBE_CYCLES), CS_N=0:
  - Read: OE=0, RD_N=0.
  - Write: OE=1, AD_OUT=data, WR_N=0.
- End of STROBE edge:
  - Strobe returns high.
  - Read: CART_AD_IN captured into TX on that edge.
- HOLD (HOLD_CYCLES): CS_N=0, strobes high, OE=0.
- Exit from HOLD: CS_N=1, BUSY=0, ADDR incremented on the same edge.
- Total BUSY duration is SETUP+1+STROBE+HOLD cycles (8 at defaults).
  - This must be shorter than one SPI word time; that is a system-level constraint and is not checked.
- RD_N and WR_N are never low simultaneously; OE is never 1 while RD_N=0.

## Structure
- Shared header cart_defs.vh holds:
  - Opcode constants (OP_NOP..OP_WRITE).
  - Status prefix 4'hA.
  - Bus-state encodings.
- Sub-module cart_bus_cycle: bus FSM, phase counter and strobe generation.
  - Inputs: start pulse, rw, addr, wdata.
  - Outputs: busy, done pulse, rdata.
- cart_command: decoder FSM, ADDR, ERR and TX.

## Test plan
- Reset: assert RST mid-read (RD_N=0) -> next edge CS_N=RD_N=1, OE=0, TX=0x0000, BUSY=0.
- Address load: words 0x1012, 0x2000, 0x3456 -> ADDR=0x123456; TX after first word = 0xA100.
- Read: ADDR=0x123456, model returns 0xBEEF; send 0x3000 -> correct phase sequence:
  - CART_A=0x12, AD_OUT=0x3456 for 2 cycles, CS_N falls, RD_N low for 4 cycles, BUSY for 8 cycles.
  - TX=0xBEEF; ADDR=0x123457.
- Write: send 0x4000, 0xCAFE -> WR_N low 4 cycles with AD_OUT=0xCAFE, OE=1, RD_N high throughout; TX=0xA400.
- Overrun: RDY with 0x1077 during a read -> ADDR[23:16] unchanged; read data still loaded; next NOP -> TX=0xA001, following NOP -> 0xA000.
- Wrap and illegal: ADDR=0xFFFFFF, READ -> ADDR=0x000000; opcode 0xF -> TX=0xAF01.

Source files
------------

// File: rtl/cart_command_pkg.sv
// cart_command_pkg: opcodes, status prefix, FSM state types and status word helper shared by the cartridge command block
package cart_command_pkg;
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_SET_HI = 4'h1;
    localparam logic [3:0] OP_SET_LO = 4'h2;
    localparam logic [3:0] OP_READ   = 4'h3;
    localparam logic [3:0] OP_WRITE  = 4'h4;
    localparam logic [3:0] STATUS_PREFIX = 4'hA;
    typedef enum logic [1:0] {IDLE, ARG_ADDR, ARG_DATA} dec_state_t;
    typedef enum logic [2:0] {B_IDLE, SETUP, LATCH, STROBE, HOLD} bus_state_t;
    function automatic logic [15:0] status_word(input logic [3:0] op, input logic err);
        return {STATUS_PREFIX, op, 7'b0, err};
    endfunction
endpackage

// File: rtl/cart_bus_cycle.sv
// cart_bus_cycle: timed GBA ROM read/write cycle on the multiplexed AD bus.
// Ports: start/rw/addr/wdata launch a cycle (rw=1 write); busy spans the cycle,
// done pulses in the last HOLD cycle, rvalid pulses in the last read STROBE cycle
// with rdata = CART_AD_IN; CART_* are the cartridge pins.
module cart_bus_cycle
    import cart_command_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        rw,
    input  logic [23:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        rvalid,
    output logic [15:0] rdata,
    output logic [7:0]  CART_A,
    output logic [15:0] CART_AD_OUT,
    output logic        CART_AD_OE,
    input  logic [15:0] CART_AD_IN,
    output logic        CART_CS_N,
    output logic        CART_RD_N,
    output logic        CART_WR_N
);
    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

    bus_state_t  state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        last, wr;
    logic [23:0] a;
    logic [15:0] d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= B_IDLE;
            cnt   <= 4'd0;
            wr    <= 1'b0;
            a     <= 24'd0;
            d     <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (start && state == B_IDLE) begin
                wr <= rw;
                a  <= addr;
                d  <= wdata;
            end
        end
    end

    always_comb begin
        last    = cnt == (state == SETUP ? SETUP_LAST : state == STROBE ? STROBE_LAST : HOLD_LAST);
        state_n = state;
        cnt_n   = last ? 4'd0 : cnt + 4'd1;
        case (state)
            B_IDLE: begin
                cnt_n = 4'd0;
                if (start) state_n = SETUP;
            end
            SETUP:  if (last) state_n = LATCH;
            LATCH: begin
                cnt_n   = 4'd0;
                state_n = STROBE;
            end
            STROBE: if (last) state_n = HOLD;
            HOLD:   if (last) state_n = B_IDLE;
            default: state_n = B_IDLE;
        endcase
    end

    assign busy        = state != B_IDLE;
    assign done        = state == HOLD && last;
    assign rvalid      = state == STROBE && last && !wr;
    assign rdata       = CART_AD_IN;
    assign CART_A      = busy ? a[23:16] : 8'h00;
    // Write data replaces the address once the strobe phase begins.
    assign CART_AD_OUT = !busy ? 16'h0000 : (wr && (state == STROBE || state == HOLD)) ? d : a[15:0];
    assign CART_AD_OE  = state == SETUP || state == LATCH || (state == STROBE && wr);
    assign CART_CS_N   = !(state == LATCH || state == STROBE || state == HOLD);
    assign CART_RD_N   = !(state == STROBE && !wr);
    assign CART_WR_N   = !(state == STROBE && wr);
endmodule

// File: rtl/cart_command.sv
// cart_command: decodes SPI command words, runs cartridge bus cycles and builds the TX response.
// Ports: CLK/RST; RX+RDY incoming word; TX response; BUSY bus cycle active;
// CART_A, CART_AD_OUT/OE/IN, CART_CS_N/RD_N/WR_N cartridge bus.
module cart_command
    import cart_command_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] RX,
    input  logic        RDY,
    output logic [15:0] TX,
    output logic        BUSY,
    output logic [7:0]  CART_A,
    output logic [15:0] CART_AD_OUT,
    output logic        CART_AD_OE,
    input  logic [15:0] CART_AD_IN,
    output logic        CART_CS_N,
    output logic        CART_RD_N,
    output logic        CART_WR_N
);
    dec_state_t  state, state_n;
    logic [23:0] addr;
    logic [3:0]  last_op, op, new_op;
    logic        err, accept, is_cmd, start, illegal, report, done, rvalid;
    logic [15:0] rdata;

    always_comb begin
        op      = RX[15:12];
        accept  = RDY && !BUSY;
        is_cmd  = state == IDLE;
        start   = accept && ((is_cmd && op == OP_READ) || state == ARG_DATA);
        illegal = is_cmd && op > OP_WRITE;
        // READ answers later with its data instead of a status word.
        report  = accept && !(is_cmd && op == OP_READ);
        new_op  = is_cmd ? op : last_op;
        state_n = !accept ? state : !is_cmd ? IDLE :
                  op == OP_SET_LO ? ARG_ADDR : op == OP_WRITE ? ARG_DATA : IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            addr    <= 24'd0;
            last_op <= OP_NOP;
            err     <= 1'b0;
            TX      <= 16'h0000;
        end else begin
            state <= state_n;
            if (accept && is_cmd) last_op <= op;
            if (accept && is_cmd && op == OP_SET_HI) addr[23:16] <= RX[7:0];
            if (accept && state == ARG_ADDR) addr[15:0] <= RX;
            if (done) addr <= addr + 24'd1;
            // Overrun drops the word; an error is cleared once it has been reported.
            err <= (RDY && BUSY) ? 1'b1 : report ? 1'b0 : err;
            if (report) TX <= status_word(new_op, err | illegal);
            else if (rvalid) TX <= rdata;
        end
    end

    cart_bus_cycle #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .STROBE_CYCLES(STROBE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_bus (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .rw         (state == ARG_DATA),
        .addr       (addr),
        .wdata      (RX),
        .busy       (BUSY),
        .done       (done),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .CART_A     (CART_A),
        .CART_AD_OUT(CART_AD_OUT),
        .CART_AD_OE (CART_AD_OE),
        .CART_AD_IN (CART_AD_IN),
        .CART_CS_N  (CART_CS_N),
        .CART_RD_N  (CART_RD_N),
        .CART_WR_N  (CART_WR_N)
    );
endmodule
